mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequencer/arbiter sharing one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store). It replaces the private instruction ROM path when the CPU runs on a unified memory. It latches one request at a time and drives the memory handshake. It returns data with one-cycle valid pulses and discards in-flight fetches killed by a PC redirect (branch/jump taken in MEM).

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data/instruction width
STARVE_LIMIT, 4, consecutive MEM grants tolerated while IF waits (used only with ARB_STARVE_GUARD_EN)

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  synchronous active-high reset
IF_Req  in  1  fetch request; held with IF_Addr until IF_Valid or IF_Flush
IF_Addr  in  ADDR_W  fetch address (PC)
IF_Flush  in  1  redirect pulse (MEM_PCSrc); kills any in-flight fetch
IF_Gnt  out  1  one-cycle pulse: fetch accepted
IF_Valid  out  1  one-cycle pulse: IF_Rdata holds the instruction
IF_Rdata  out  DATA_W  fetched instruction
IF_Stall  out  1  IF_Req & ~IF_Valid (combinational)
MEM_Req  in  1  data request; held with the MEM_* inputs until MEM_Valid
MEM_We  in  1  1 = store, 0 = load
MEM_Addr  in  ADDR_W  data address
MEM_Wdata  in  DATA_W  store data
MEM_Gnt  out  1  one-cycle pulse: data access accepted
MEM_Valid  out  1  one-cycle pulse: access complete; MEM_Rdata valid for loads
MEM_Rdata  out  DATA_W  load data
MEM_Stall  out  1  MEM_Req & ~MEM_Valid (combinational)
M_Req  out  1  memory request, held until M_Ready
M_We  out  1  memory write enable
M_Addr  out  ADDR_W  memory address
M_Wdata  out  DATA_W  memory write data
M_Ready  in  1  memory completion, sampled only while M_Req=1
M_Rdata  in  DATA_W  memory read data, valid when M_Ready=1

Behaviour:
- All outputs except IF_Stall and MEM_Stall are registered. States are IDLE, IF_BUSY and MEM_BUSY.
- Reset (Clr=1 at an edge): state IDLE. All registered outputs go to 0, including Rdata registers. Drop flag and starve counter clear. Reset mid-transaction abandons it: M_Req is deasserted next cycle and no Valid pulse is issued.
- IDLE arbitration:
  - MEM_Req wins (older instruction). Else IF_Req is granted. Else stay in IDLE.
  - On grant: latch address, We and Wdata into the M_* registers; set M_Req=1; pulse the matching Gnt; enter the BUSY state.
  - An IF grant always has M_We=0.
- BUSY states:
  - M_* outputs are held stable until M_Ready=1 with M_Req=1.
  - At that edge: M_Req returns to 0 and the state returns to IDLE.
  - The matching Valid pulses for one cycle. Rdata is loaded from M_Rdata. For stores MEM_Rdata holds its previous value.
- Latency: if a request is seen in IDLE at cycle t and M_Ready arrives at cycle t+k (k≥1), Valid is high in cycle t+k+1. That cycle is IDLE and re-arbitration happens in it: exactly one idle bubble between transactions.
- Flush handling:
  - IF_Flush in IF_BUSY, including the same cycle as M_Ready, sets the drop flag.
  - The memory transaction still completes, but IF_Valid stays 0 and IF_Rdata is unchanged. The drop flag clears on return to IDLE.
  - IF_Flush in IDLE or MEM_BUSY has no effect; the requester presents the redirected PC on IF_Addr.
- IF_Req falling while in IF_BUSY is treated as a flush.
- Never two outstanding memory requests; M_Req=1 only in the BUSY states.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A counter increments on each MEM grant made while IF_Req=1. It clears on an IF grant or whenever IF_Req=0.
  - When the counter equals STARVE_LIMIT, IDLE arbitration grants IF ahead of MEM.
- Undefined: strict MEM priority; no counter logic is synthesised.

Test Plan:
- Reset: Clr=1 for 2 cycles during MEM_BUSY -> next cycle M_Req=0; all Valid/Gnt=0; no MEM_Valid ever issued for the abandoned access.
- Fetch, latency 3: IF_Req, IF_Addr=0x40 at cycle 0 -> IF_Gnt and M_Req=1 with M_Addr=0x40 in cycle 1. M_Ready=1, M_Rdata=0x8C010004 in cycle 3 -> IF_Valid=1, IF_Rdata=0x8C010004 in cycle 4; M_Req=0 in cycle 4.
- Conflict: MEM_Req (load 0x100) and IF_Req (0x44) both at cycle 0, memory latency 1 -> MEM_Gnt in cycle 1, MEM_Valid in cycle 3; IF_Gnt in cycle 4; IF_Stall=1 throughout cycles 0–5.
- Store: MEM_We=1, MEM_Addr=0x200, MEM_Wdata=0xDEADBEEF -> M_We=1, M_Wdata=0xDEADBEEF; MEM_Valid pulses once; MEM_Rdata unchanged.
- Flush: fetch 0x48 in flight, IF_Flush pulse one cycle before M_Ready, IF_Addr changed to 0x300 -> no IF_Valid for 0x48. Next grant has M_Addr=0x300 and its data is returned on IF_Valid.
- Starvation: STARVE_LIMIT=2, MEM_Req held continuously, IF_Req held -> with ARB_STARVE_GUARD_EN, IF is granted after exactly 2 MEM transactions. Without it, IF is never granted while MEM_Req=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (MEM); optional ARB_STARVE_GUARD_EN bounds IF starvation.
// Latency: grant registered one cycle after request; Valid one cycle after M_Ready; one idle bubble between accesses.
// Backpressure: requesters hold Req until Valid (IF also until Flush); memory holds off via M_Ready, M_* held stable.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  input  logic              IF_Flush,
  output logic              IF_Gnt,
  output logic              IF_Valid,
  output logic [DATA_W-1:0] IF_Rdata,
  output logic              IF_Stall,
  input  logic              MEM_Req,
  input  logic              MEM_We,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [DATA_W-1:0] MEM_Wdata,
  output logic              MEM_Gnt,
  output logic              MEM_Valid,
  output logic [DATA_W-1:0] MEM_Rdata,
  output logic              MEM_Stall,
  output logic              M_Req,
  output logic              M_We,
  output logic [ADDR_W-1:0] M_Addr,
  output logic [DATA_W-1:0] M_Wdata,
  input  logic              M_Ready,
  input  logic [DATA_W-1:0] M_Rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic              if_gnt_d, if_valid_d, mem_gnt_d, mem_valid_d;
  logic              m_req_d, m_we_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_wdata_d, if_rdata_d, mem_rdata_d;
  logic              if_first;
  logic              if_killed;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;

  // Counts MEM wins over a waiting fetch; any gap in IF_Req forgives the history.
  always_ff @(posedge Clk) begin
    if (Clr)
      starve_q <= '0;
    else if (!IF_Req || if_gnt_d)
      starve_q <= '0;
    else if (mem_gnt_d && (starve_q != CNT_W'(STARVE_LIMIT)))
      starve_q <= starve_q + CNT_W'(1);
  end

  assign if_first = (starve_q == CNT_W'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign if_first            = 1'b0;
`endif

  // A falling IF_Req mid-fetch means the fetch was abandoned, same as a redirect.
  assign if_killed = drop_q | IF_Flush | ~IF_Req;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    if_gnt_d    = 1'b0;
    mem_gnt_d   = 1'b0;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    m_req_d     = M_Req;
    m_we_d      = M_We;
    m_addr_d    = M_Addr;
    m_wdata_d   = M_Wdata;
    if_rdata_d  = IF_Rdata;
    mem_rdata_d = MEM_Rdata;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (IF_Req && (if_first || !MEM_Req)) begin
          if_gnt_d = 1'b1;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = IF_Addr;
          state_d  = IF_BUSY;
        end else if (MEM_Req) begin
          mem_gnt_d = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = MEM_We;
          m_addr_d  = MEM_Addr;
          m_wdata_d = MEM_Wdata;
          state_d   = MEM_BUSY;
        end
      end
      IF_BUSY: begin
        if (IF_Flush || !IF_Req)
          drop_d = 1'b1;
        if (M_Ready) begin
          m_req_d = 1'b0;
          drop_d  = 1'b0;
          state_d = IDLE;
          if (!if_killed) begin
            if_valid_d = 1'b1;
            if_rdata_d = M_Rdata;
          end
        end
      end
      MEM_BUSY: begin
        if (M_Ready) begin
          m_req_d     = 1'b0;
          state_d     = IDLE;
          mem_valid_d = 1'b1;
          if (!M_We)
            mem_rdata_d = M_Rdata;
        end
      end
      default: begin
        m_req_d = 1'b0;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      IF_Gnt    <= 1'b0;
      IF_Valid  <= 1'b0;
      IF_Rdata  <= '0;
      MEM_Gnt   <= 1'b0;
      MEM_Valid <= 1'b0;
      MEM_Rdata <= '0;
      M_Req     <= 1'b0;
      M_We      <= 1'b0;
      M_Addr    <= '0;
      M_Wdata   <= '0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      IF_Gnt    <= if_gnt_d;
      IF_Valid  <= if_valid_d;
      IF_Rdata  <= if_rdata_d;
      MEM_Gnt   <= mem_gnt_d;
      MEM_Valid <= mem_valid_d;
      MEM_Rdata <= mem_rdata_d;
      M_Req     <= m_req_d;
      M_We      <= m_we_d;
      M_Addr    <= m_addr_d;
      M_Wdata   <= m_wdata_d;
    end
  end

  assign IF_Stall  = IF_Req & ~IF_Valid;
  assign MEM_Stall = MEM_Req & ~MEM_Valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LIM = 2;

  logic        clk, clr;
  logic        if_req, if_flush, if_gnt, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_valid, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        m_req, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .Clk(clk), .Clr(clr),
    .IF_Req(if_req), .IF_Addr(if_addr), .IF_Flush(if_flush),
    .IF_Gnt(if_gnt), .IF_Valid(if_valid), .IF_Rdata(if_rdata), .IF_Stall(if_stall),
    .MEM_Req(mem_req), .MEM_We(mem_we), .MEM_Addr(mem_addr), .MEM_Wdata(mem_wdata),
    .MEM_Gnt(mem_gnt), .MEM_Valid(mem_valid), .MEM_Rdata(mem_rdata), .MEM_Stall(mem_stall),
    .M_Req(m_req), .M_We(m_we), .M_Addr(m_addr), .M_Wdata(m_wdata),
    .M_Ready(m_ready), .M_Rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing store of the simulated memory; unwritten words hold an address hash.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  task automatic new_mem_req();
    mem_req   = 1'b1;
    mem_we    = 1'($urandom_range(0, 1));
    mem_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
    mem_wdata = $urandom;
  endtask

  // Transaction-level model state
  bit          busy, owner_if, killed, starve_hit, pick_if, pick_mem;
  int          cnt, lat;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;
  bit          e_we, e_if_gnt, e_mem_gnt, e_if_valid, e_mem_valid, e_m_req;
  int          seen, mem_grants, if_grants, mem_before_if;

  initial begin
    clr = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    m_ready = 0; m_rdata = 0;

    // Reset state
    step(); step();
    chk("rst_m_req", m_req, 0);
    chk("rst_pulses", {if_gnt, mem_gnt, if_valid, mem_valid}, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    chk("rst_m_addr", m_addr, 0);
    clr = 1'b0;
    step();

    // Fetch with memory latency 3
    if_req = 1; if_addr = 32'h40; #1;
    chk("fetch_stall_c0", if_stall, 1);
    step();
    chk("fetch_gnt", if_gnt, 1); chk("fetch_m_req", m_req, 1);
    chk("fetch_m_addr", m_addr, 32'h40); chk("fetch_m_we", m_we, 0);
    step();
    chk("fetch_gnt_pulse", if_gnt, 0); chk("fetch_m_req_held", m_req, 1);
    step();
    m_ready = 1; m_rdata = 32'h8C010004;
    step();
    m_ready = 0;
    chk("fetch_valid", if_valid, 1); chk("fetch_rdata", if_rdata, 32'h8C010004);
    chk("fetch_m_req_drop", m_req, 0);
    if_req = 0;
    step();
    chk("fetch_valid_pulse", if_valid, 0);

    // Conflict: MEM wins, IF follows after one bubble
    mem_req = 1; mem_we = 0; mem_addr = 32'h100; if_req = 1; if_addr = 32'h44; #1;
    chk("conf_stall_c0", if_stall, 1);
    step();
    chk("conf_mem_gnt", mem_gnt, 1); chk("conf_if_gnt_c1", if_gnt, 0);
    chk("conf_m_addr", m_addr, 32'h100); chk("conf_stall_c1", if_stall, 1);
    step();
    m_ready = 1; m_rdata = 32'h11112222;
    step();
    m_ready = 0;
    chk("conf_mem_valid", mem_valid, 1); chk("conf_mem_rdata", mem_rdata, 32'h11112222);
    mem_req = 0; #1;
    chk("conf_stall_c3", if_stall, 1);
    step();
    chk("conf_if_gnt_c4", if_gnt, 1); chk("conf_m_addr_if", m_addr, 32'h44);
    step();
    chk("conf_stall_c5", if_stall, 1);
    m_ready = 1; m_rdata = 32'h33334444;
    step();
    m_ready = 0;
    chk("conf_if_valid", if_valid, 1); chk("conf_if_rdata", if_rdata, 32'h33334444);
    chk("conf_stall_c6", if_stall, 0);
    if_req = 0;
    step();

    // Store
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    step();
    chk("st_gnt", mem_gnt, 1); chk("st_m_we", m_we, 1);
    chk("st_m_wdata", m_wdata, 32'hDEADBEEF); chk("st_m_addr", m_addr, 32'h200);
    m_ready = 1; m_rdata = 32'h55556666;
    step();
    m_ready = 0;
    chk("st_valid", mem_valid, 1); chk("st_rdata_held", mem_rdata, 32'h11112222);
    mem_req = 0; mem_we = 0;
    step();
    chk("st_valid_pulse", mem_valid, 0); chk("st_m_req_drop", m_req, 0);

    // Flush one cycle before M_Ready
    if_req = 1; if_addr = 32'h48;
    step();
    chk("fl_gnt", if_gnt, 1); chk("fl_m_addr", m_addr, 32'h48);
    step();
    if_flush = 1; if_addr = 32'h300;
    step();
    if_flush = 0; m_ready = 1; m_rdata = 32'hBAD0BAD0;
    step();
    m_ready = 0;
    chk("fl_no_valid", if_valid, 0); chk("fl_rdata_held", if_rdata, 32'h33334444);
    step();
    chk("fl_regnt", if_gnt, 1); chk("fl_regnt_addr", m_addr, 32'h300);
    m_ready = 1; m_rdata = 32'h0300ABCD;
    step();
    m_ready = 0;
    chk("fl_valid", if_valid, 1); chk("fl_rdata", if_rdata, 32'h0300ABCD);

    // Flush in the same cycle as M_Ready
    if_addr = 32'h4C;
    step();
    chk("fl2_gnt", if_gnt, 1); chk("fl2_m_addr", m_addr, 32'h4C);
    step();
    if_flush = 1; if_addr = 32'h304; m_ready = 1; m_rdata = 32'hBAD1BAD1;
    step();
    if_flush = 0; m_ready = 0;
    chk("fl2_no_valid", if_valid, 0); chk("fl2_rdata_held", if_rdata, 32'h0300ABCD);
    step();
    chk("fl2_regnt", if_gnt, 1); chk("fl2_regnt_addr", m_addr, 32'h304);
    m_ready = 1; m_rdata = 32'h0304AAAA;
    step();
    m_ready = 0;
    chk("fl2_valid", if_valid, 1); chk("fl2_rdata", if_rdata, 32'h0304AAAA);
    if_req = 0;
    step();

    // Reset in the middle of a MEM access
    mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    step();
    chk("mrst_gnt", mem_gnt, 1); chk("mrst_m_req", m_req, 1);
    clr = 1; mem_req = 0;
    step();
    chk("mrst_m_req_drop", m_req, 0); chk("mrst_gnt_clr", mem_gnt, 0);
    chk("mrst_if_rdata", if_rdata, 0);
    step();
    clr = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      m_ready = 1;
      step();
      seen += int'(mem_valid) + int'(m_req);
    end
    m_ready = 0;
    chk("mrst_abandoned", seen, 0);

    // Starvation with MEM_Req and IF_Req held
    mem_req = 1; mem_we = 0; mem_addr = 32'h500; if_req = 1; if_addr = 32'h600;
    mem_grants = 0; if_grants = 0; mem_before_if = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      m_ready = m_req;
      if (if_gnt && mem_before_if < 0) mem_before_if = mem_grants;
      if (mem_gnt) mem_grants++;
      if (if_gnt) if_grants++;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_if_after_limit", mem_before_if, LIM);
`else
    chk("starve_no_if_gnt", if_grants, 0);
`endif
    chk("starve_mem_progress", (mem_grants >= 8), 1);
    mem_req = 0; if_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      m_ready = m_req;
    end
    m_ready = 0;

    // Randomized traffic against the model
    clr = 1;
    step(); step();
    clr = 0;
    busy = 0; owner_if = 0; killed = 0; cnt = 0; lat = 0;
    e_addr = 0; e_wdata = 0; e_we = 0; e_if_rdata = 0; e_mem_rdata = 0;
    e_if_gnt = 0; e_mem_gnt = 0; e_if_valid = 0; e_mem_valid = 0; e_m_req = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("r_if_gnt", if_gnt, e_if_gnt);
      chk("r_mem_gnt", mem_gnt, e_mem_gnt);
      chk("r_if_valid", if_valid, e_if_valid);
      chk("r_mem_valid", mem_valid, e_mem_valid);
      chk("r_if_rdata", if_rdata, e_if_rdata);
      chk("r_mem_rdata", mem_rdata, e_mem_rdata);
      chk("r_m_req", m_req, e_m_req);
      if (e_m_req) begin
        chk("r_m_addr", m_addr, e_addr);
        chk("r_m_we", m_we, e_we);
        if (e_we) chk("r_m_wdata", m_wdata, e_wdata);
      end

      // Fetch requester
      if_flush = 0;
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = 32'($urandom_range(32'h3F0, 32'h40F)) * 4;
        end
      end else if (if_valid) begin
        if ($urandom_range(0, 1) == 1) if_addr = if_addr + 4;
        else if_req = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        if_flush = 1; if_addr = 32'($urandom_range(32'h3F0, 32'h40F)) * 4;
      end else if ($urandom_range(0, 29) == 0) begin
        if_req = 0;
      end

      // Load/store requester
      if (!mem_req) begin
        if ($urandom_range(0, 2) == 0) new_mem_req();
      end else if (mem_valid) begin
        if ($urandom_range(0, 1) == 1) new_mem_req();
        else mem_req = 0;
      end

      // Memory with random latency
      m_ready = 0;
      m_rdata = $urandom;
      if (if_gnt || mem_gnt) lat = $urandom_range(0, 3);
      if (m_req) begin
        if (lat == 0) begin
          m_ready = 1;
          m_rdata = ref_read(m_addr);
          if (m_we) ref_mem[m_addr] = m_wdata;
        end else begin
          lat--;
        end
      end

      #1;
      chk("r_if_stall", if_stall, if_req & ~e_if_valid);
      chk("r_mem_stall", mem_stall, mem_req & ~e_mem_valid);

      // Predict next cycle: who owns the memory and what completes
      e_if_gnt = 0; e_mem_gnt = 0; e_if_valid = 0; e_mem_valid = 0;
      pick_if = 0; pick_mem = 0;
`ifdef ARB_STARVE_GUARD_EN
      starve_hit = (cnt == LIM);
`else
      starve_hit = 0;
`endif
      if (!busy) begin
        pick_if  = if_req && (starve_hit || !mem_req);
        pick_mem = mem_req && !pick_if;
        if (pick_if) begin
          busy = 1; owner_if = 1; killed = 0; e_addr = if_addr; e_we = 0; e_if_gnt = 1;
        end else if (pick_mem) begin
          busy = 1; owner_if = 0; e_addr = mem_addr; e_we = mem_we;
          e_wdata = mem_wdata; e_mem_gnt = 1;
        end
      end else begin
        if (owner_if && (if_flush || !if_req)) killed = 1;
        if (m_ready) begin
          busy = 0;
          if (owner_if) begin
            if (!killed) begin
              e_if_valid = 1; e_if_rdata = ref_read(e_addr);
            end
          end else begin
            e_mem_valid = 1;
            if (!e_we) e_mem_rdata = ref_read(e_addr);
          end
        end
      end
      if (!if_req || pick_if) cnt = 0;
      else if (pick_mem) cnt++;
      e_m_req = busy;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
